// File: rtl/hdmi_timing_pkg.sv
// Shared 720p timing constants, coordinate type and the block-mover state encoding.
package hdmi_timing_pkg;

  localparam int COORD_W = 11;

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t H_DISP_720P = 11'd1280;
  localparam coord_t V_DISP_720P = 11'd720;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    CALC       = 2'd2,
    COMMIT     = 2'd3
  } move_state_e;

endpackage

// File: rtl/axis_bounce.sv
// Single-axis next position/direction for a square block bouncing between 0 and LIMIT-BLOCK_SIZE.
module axis_bounce
  import hdmi_timing_pkg::*;
#(
  parameter coord_t LIMIT      = H_DISP_720P,
  parameter coord_t BLOCK_SIZE = 11'd40,
  parameter coord_t STEP       = 11'd2
) (
  input  coord_t pos_i,
  input  logic   dir_i,
  output coord_t pos_o,
  output logic   dir_o,
  output logic   flip_o
);

  // One extra bit so pos + size + step can never wrap.
  logic [COORD_W:0] pos_w;
  logic [COORD_W:0] step_w;
  logic [COORD_W:0] limit_w;
  logic [COORD_W:0] far_edge_w;
  logic [COORD_W:0] max_pos_w;

  always_comb begin
    pos_w      = {1'b0, pos_i};
    step_w     = {1'b0, STEP};
    limit_w    = {1'b0, LIMIT};
    far_edge_w = pos_w + {1'b0, BLOCK_SIZE} + step_w;
    max_pos_w  = limit_w - {1'b0, BLOCK_SIZE};
    pos_o      = pos_i;
    dir_o      = dir_i;
    if (dir_i) begin
      if (far_edge_w >= limit_w) begin
        pos_o = max_pos_w[COORD_W-1:0];
        dir_o = 1'b0;
      end else begin
        pos_o = pos_i + STEP;
      end
    end else begin
      if (pos_w <= step_w) begin
        pos_o = '0;
        dir_o = 1'b1;
      end else begin
        pos_o = pos_i - STEP;
      end
    end
    flip_o = (dir_o != dir_i);
  end

endmodule

// File: rtl/block_move_ctrl.sv
// Moving-block scheduler: counts vsync edges and steps the block position, committing
// only inside vertical sync so the displayed frame never tears.
module block_move_ctrl
  import hdmi_timing_pkg::*;
#(
  parameter coord_t     H_DISP     = H_DISP_720P,
  parameter coord_t     V_DISP     = V_DISP_720P,
  parameter coord_t     BLOCK_SIZE = 11'd40,
  parameter coord_t     STEP_X     = 11'd2,
  parameter coord_t     STEP_Y     = 11'd2,
  parameter logic [7:0] FRAME_DIV  = 8'd1,
  parameter coord_t     X_INIT     = 11'd0,
  parameter coord_t     Y_INIT     = 11'd0
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic        video_vs,
  input  logic        move_en,
  output logic [10:0] block_x,
  output logic [10:0] block_y,
  output logic        dir_x,
  output logic        dir_y,
  output logic        pos_update,
  output logic        bounce_x,
  output logic        bounce_y,
  output move_state_e state_dbg
);

  move_state_e state_q, state_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        vs_q;
  logic        frame_tick;
  logic        commit;
  coord_t      x_q, y_q;
  logic        dx_q, dy_q;
  logic        pos_update_q, bounce_x_q, bounce_y_q;
  coord_t      nx, ny;
  logic        ndx, ndy, flip_x, flip_y;

  assign frame_tick = video_vs & ~vs_q;
  assign commit     = (state_q == CALC);

  axis_bounce #(
    .LIMIT      (H_DISP),
    .BLOCK_SIZE (BLOCK_SIZE),
    .STEP       (STEP_X)
  ) u_axis_x (
    .pos_i  (x_q),
    .dir_i  (dx_q),
    .pos_o  (nx),
    .dir_o  (ndx),
    .flip_o (flip_x)
  );

  axis_bounce #(
    .LIMIT      (V_DISP),
    .BLOCK_SIZE (BLOCK_SIZE),
    .STEP       (STEP_Y)
  ) u_axis_y (
    .pos_i  (y_q),
    .dir_i  (dy_q),
    .pos_o  (ny),
    .dir_o  (ndy),
    .flip_o (flip_y)
  );

  // move_en has priority over a coincident frame tick in WAIT_FRAME.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (move_en) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (!move_en) begin
          state_d = IDLE;
        end else if (frame_tick) begin
          if (frame_cnt_q == FRAME_DIV - 8'd1) begin
            frame_cnt_d = '0;
            state_d     = CALC;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      CALC:    state_d = COMMIT;
      COMMIT:  state_d = WAIT_FRAME;
      default: state_d = IDLE;
    endcase
  end

  // The CALC-cycle result lands on the edge into COMMIT, so the COMMIT cycle shows
  // the new position together with its pulses.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      frame_cnt_q  <= '0;
      vs_q         <= 1'b0;
      x_q          <= X_INIT;
      y_q          <= Y_INIT;
      dx_q         <= 1'b1;
      dy_q         <= 1'b1;
      pos_update_q <= 1'b0;
      bounce_x_q   <= 1'b0;
      bounce_y_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      vs_q         <= video_vs;
      pos_update_q <= commit;
      bounce_x_q   <= commit & flip_x;
      bounce_y_q   <= commit & flip_y;
      if (commit) begin
        x_q  <= nx;
        y_q  <= ny;
        dx_q <= ndx;
        dy_q <= ndy;
      end
    end
  end

  assign block_x    = x_q;
  assign block_y    = y_q;
  assign dir_x      = dx_q;
  assign dir_y      = dy_q;
  assign pos_update = pos_update_q;
  assign bounce_x   = bounce_x_q;
  assign bounce_y   = bounce_y_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_block_move_ctrl.sv
// Bench for block_move_ctrl: four parameterisations share one stimulus stream and are
// checked every cycle against a frame-level model, plus literal checkpoints.
module tb_block_move_ctrl;
  import hdmi_timing_pkg::*;

  localparam int BS = 40;
  localparam int HD = 1280;
  localparam int VD = 720;
  localparam int ST = 2;
  localparam int XI  [4] = '{0, 1238, 1240, 0};
  localparam int YI  [4] = '{0, 0, 680, 0};
  localparam int DIV [4] = '{1, 1, 1, 3};

  // clock / reset
  logic clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic video_vs = 1'b0;
  logic move_en = 1'b0;
  always #5 clk = ~clk;

  logic [3:0][10:0] bxs, bys;
  logic [3:0]       dxs, dys, pus, bnx, bny;
  move_state_e      st0, st1, st2, st3;

  block_move_ctrl u0 (
    .pixel_clk(clk), .sys_rst_n(sys_rst_n), .video_vs(video_vs), .move_en(move_en),
    .block_x(bxs[0]), .block_y(bys[0]), .dir_x(dxs[0]), .dir_y(dys[0]),
    .pos_update(pus[0]), .bounce_x(bnx[0]), .bounce_y(bny[0]), .state_dbg(st0));
  block_move_ctrl #(.X_INIT(11'd1238)) u1 (
    .pixel_clk(clk), .sys_rst_n(sys_rst_n), .video_vs(video_vs), .move_en(move_en),
    .block_x(bxs[1]), .block_y(bys[1]), .dir_x(dxs[1]), .dir_y(dys[1]),
    .pos_update(pus[1]), .bounce_x(bnx[1]), .bounce_y(bny[1]), .state_dbg(st1));
  block_move_ctrl #(.X_INIT(11'd1240), .Y_INIT(11'd680)) u2 (
    .pixel_clk(clk), .sys_rst_n(sys_rst_n), .video_vs(video_vs), .move_en(move_en),
    .block_x(bxs[2]), .block_y(bys[2]), .dir_x(dxs[2]), .dir_y(dys[2]),
    .pos_update(pus[2]), .bounce_x(bnx[2]), .bounce_y(bny[2]), .state_dbg(st2));
  block_move_ctrl #(.FRAME_DIV(8'd3)) u3 (
    .pixel_clk(clk), .sys_rst_n(sys_rst_n), .video_vs(video_vs), .move_en(move_en),
    .block_x(bxs[3]), .block_y(bys[3]), .dir_x(dxs[3]), .dir_y(dys[3]),
    .pos_update(pus[3]), .bounce_x(bnx[3]), .bounce_y(bny[3]), .state_dbg(st3));

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int pu_cnt [4] = '{0, 0, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    n_total++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // behavioural model: frame counting and bounce arithmetic straight from the rules
  function automatic void axis_step(input int pos, input int dir, input int limit,
                                    output int npos, output int ndir);
    if (dir == 1) begin
      if (pos + BS + ST >= limit) begin npos = limit - BS; ndir = 0; end
      else begin npos = pos + ST; ndir = 1; end
    end else begin
      if (pos <= ST) begin npos = 0; ndir = 1; end
      else begin npos = pos - ST; ndir = 0; end
    end
  endfunction

  int m_x [4], m_y [4], m_dx [4], m_dy [4], m_cnt [4], m_due [4];
  bit m_pu [4], m_bx [4], m_by [4];
  bit prev_vs, prev_en;
  logic [26:0] exp_q[$];

  // scoreboard: every cycle, every instance
  always @(negedge clk) begin : cmp
    int nx, ndx, ny, ndy;
    bit busy, tick;
    logic [26:0] got, want;
    if (!sys_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_x[i] = XI[i]; m_y[i] = YI[i]; m_dx[i] = 1; m_dy[i] = 1;
        m_cnt[i] = 0; m_due[i] = -1; m_pu[i] = 0; m_bx[i] = 0; m_by[i] = 0;
      end
      exp_q.delete();
      prev_vs = 0;
      prev_en = 0;
    end else begin
      tick = video_vs && !prev_vs;
      for (int i = 0; i < 4; i++) begin
        busy = (m_due[i] >= 0);
        m_pu[i] = 0; m_bx[i] = 0; m_by[i] = 0;
        if (m_due[i] == cyc) begin
          axis_step(m_x[i], m_dx[i], HD, nx, ndx);
          axis_step(m_y[i], m_dy[i], VD, ny, ndy);
          m_bx[i] = (ndx != m_dx[i]);
          m_by[i] = (ndy != m_dy[i]);
          m_x[i] = nx; m_y[i] = ny; m_dx[i] = ndx; m_dy[i] = ndy;
          m_pu[i] = 1;
          m_due[i] = -1;
        end
        if (tick && move_en && prev_en && !busy) begin
          m_cnt[i]++;
          if (m_cnt[i] == DIV[i]) begin
            m_cnt[i] = 0;
            m_due[i] = cyc + 2;
            if (i == 0) begin
              axis_step(m_x[0], m_dx[0], HD, nx, ndx);
              axis_step(m_y[0], m_dy[0], VD, ny, ndy);
              exp_q.push_back({11'(nx), 11'(ny), 1'(ndx), 1'(ndy), 1'b1,
                               1'(ndx != m_dx[0]), 1'(ndy != m_dy[0])});
            end
          end
        end
      end
      prev_vs = video_vs;
      prev_en = move_en;
    end
    for (int i = 0; i < 4; i++) begin
      got  = {bxs[i], bys[i], dxs[i], dys[i], pus[i], bnx[i], bny[i]};
      want = {11'(m_x[i]), 11'(m_y[i]), 1'(m_dx[i]), 1'(m_dy[i]), m_pu[i], m_bx[i], m_by[i]};
      n_total++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL cycle_cmp u%0d cyc=%0d got=%h want=%h", i, cyc, got, want);
      end
      if (pus[i] === 1'b1) pu_cnt[i]++;
    end
    if (sys_rst_n && pus[0] === 1'b1) begin
      got = {bxs[0], bys[0], dxs[0], dys[0], pus[0], bnx[0], bny[0]};
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL commit_q: unexpected update got=%h want none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_bad++;
          $display("FAIL commit_q: got=%h want=%h", got, want);
        end
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the caller in the cycle right after the vsync rising edge.
  task automatic vs_rise(input int lo, input bit en);
    move_en  = en;
    video_vs = 1'b0;
    step(lo);
    video_vs = 1'b1;
    step(1);
  endtask

  task automatic frame(input int lo, input int hi, input bit en);
    vs_rise(lo, en);
    step(hi - 1);
  endtask

  initial begin
    step(3);
    sys_rst_n = 1'b1;
    step(1);
    check("rst_x0", int'(bxs[0]), 0);
    check("rst_y0", int'(bys[0]), 0);
    check("rst_dir0", int'({dxs[0], dys[0]}), 3);
    check("rst_x1", int'(bxs[1]), 1238);

    // frozen: vsyncs must not move anything
    for (int k = 0; k < 5; k++) frame(5, 4, 1'b0);
    check("frozen_x0", int'(bxs[0]), 0);
    check("frozen_y0", int'(bys[0]), 0);
    check("frozen_dir0", int'({dxs[0], dys[0]}), 3);
    check("frozen_pu", pu_cnt[0] + pu_cnt[1] + pu_cnt[2] + pu_cnt[3], 0);

    // first enabled frame: latency, plain step, single bounce, corner bounce
    vs_rise(5, 1'b1);
    check("pu_early", int'(pus[0]), 0);
    step(1);
    check("pu_n2", int'(pus[0]), 1);
    check("step_x0", int'(bxs[0]), 2);
    check("step_y0", int'(bys[0]), 2);
    check("edge_x1", int'(bxs[1]), 1240);
    check("edge_bx1", int'(bnx[1]), 1);
    check("edge_by1", int'(bny[1]), 0);
    check("edge_dx1", int'(dxs[1]), 0);
    check("corner_xy2", int'({bxs[2], bys[2]}), int'({11'd1240, 11'd680}));
    check("corner_bnc2", int'({bnx[2], bny[2]}), 3);
    check("corner_dir2", int'({dxs[2], dys[2]}), 0);
    check("div3_idle", int'(pus[3]), 0);
    step(3);
    check("pu_pulse", int'(pus[0]), 0);

    frame(6, 4, 1'b1);
    check("back_x1", int'(bxs[1]), 1238);
    check("back_xy2", int'({bxs[2], bys[2]}), int'({11'd1238, 11'd678}));
    frame(6, 4, 1'b1);
    check("div3_x3", int'(bxs[3]), 2);
    check("div3_cnt3", pu_cnt[3], 1);

    // frame divider holds its count while disabled
    frame(6, 4, 1'b1);
    frame(6, 4, 1'b0);
    frame(6, 4, 1'b0);
    for (int k = 0; k < 5; k++) frame(6, 4, 1'b1);
    check("div3_pulses", pu_cnt[3], 3);
    check("div3_x3b", int'(bxs[3]), 6);
    check("nine_x0", int'(bxs[0]), 18);

    // randomized frames
    for (int k = 0; k < 600; k++)
      frame($urandom_range(4, 12), $urandom_range(3, 8), $urandom_range(0, 9) != 0);

    // reset during CALC: immediate reset values, no commit
    vs_rise(6, 1'b1);
    sys_rst_n = 1'b0;
    #1;
    check("rstcalc_x0", int'(bxs[0]), 0);
    check("rstcalc_y0", int'(bys[0]), 0);
    check("rstcalc_x1", int'(bxs[1]), 1238);
    check("rstcalc_pu", int'(pus), 0);
    step(2);
    video_vs  = 1'b0;
    move_en   = 1'b0;
    step(1);
    sys_rst_n = 1'b1;
    step(2);
    vs_rise(5, 1'b1);
    step(1);
    check("resume_pu0", int'(pus[0]), 1);
    check("resume_x0", int'(bxs[0]), 2);
    check("resume_y0", int'(bys[0]), 2);
    check("resume_x1", int'(bxs[1]), 1240);
    step(4);
    check("commit_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/block_move_ctrl.md
Name: block_move_ctrl

Overview:
Motion scheduler for the moving-block HDMI demo. Sits in the pixel_clk domain between video_driver and video_display.
- Watches the vertical sync from video_driver.
- Once every FRAME_DIV frames, advances the block's top-left position with edge bounce.
- Commits the new position only during vertical sync, so the visible frame never tears.
- video_display consumes block_x/block_y to draw the block.

Parameters:
H_DISP, 11'd1280, active pixels per line
V_DISP, 11'd720, active lines per frame
BLOCK_SIZE, 11'd40, block edge length in pixels (square)
STEP_X, 11'd2, horizontal pixels moved per update
STEP_Y, 11'd2, vertical pixels moved per update
FRAME_DIV, 8'd1, frames per position update (1..255)
X_INIT, 11'd0, reset X position
Y_INIT, 11'd0, reset Y position

Ports:
pixel_clk  input  1  pixel clock; all logic rising-edge
sys_rst_n  input  1  asynchronous active-low reset
video_vs  input  1  vertical sync from video_driver, active high
move_en  input  1  1 = motion enabled, 0 = block frozen in place
block_x  output  11  committed block left edge, 0..H_DISP-BLOCK_SIZE
block_y  output  11  committed block top edge, 0..V_DISP-BLOCK_SIZE
dir_x  output  1  1 = moving right, 0 = moving left
dir_y  output  1  1 = moving down, 0 = moving up
pos_update  output  1  one-cycle pulse on the cycle block_x/block_y change
bounce_x  output  1  one-cycle pulse with pos_update when X direction flipped
bounce_y  output  1  one-cycle pulse with pos_update when Y direction flipped

Behaviour:
Reset values:
- block_x=X_INIT, block_y=Y_INIT, dir_x=1, dir_y=1.
- pos_update=0, bounce_x=0, bounce_y=0, frame_cnt=0, state=IDLE.
- Clock and reset ports use the codebase names; reset is asynchronous assert, active-low.

Frame detection:
- video_vs is registered once (vs_d).
- frame_tick = video_vs & ~vs_d (rising edge), asserted for one cycle.

State machine:
- IDLE: move_en=1 -> WAIT_FRAME.
- WAIT_FRAME:
  - move_en=0 -> IDLE.
  - On frame_tick: if frame_cnt==FRAME_DIV-1, clear frame_cnt and go to CALC; else increment frame_cnt and stay.
- CALC (1 cycle): compute nx, ny, ndx, ndy into holding registers using 12-bit arithmetic (no overflow). Go to COMMIT.
  - X, moving right: if block_x+BLOCK_SIZE+STEP_X >= H_DISP then nx=H_DISP-BLOCK_SIZE, ndx=0; else nx=block_x+STEP_X.
  - X, moving left: if block_x <= STEP_X then nx=0, ndx=1; else nx=block_x-STEP_X.
  - Y: same rules using V_DISP and STEP_Y.
- COMMIT (1 cycle): load block_x/y and dir_x/y; pulse pos_update; pulse bounce_x/bounce_y where the direction changed. Go to WAIT_FRAME.

Latency and cycle rules:
- frame_tick at cycle N -> CALC at N+1 -> outputs change and pos_update=1 at N+2.
- move_en sampled only in IDLE and WAIT_FRAME. Deasserting it during CALC/COMMIT lets the update complete; the FSM then goes to IDLE from WAIT_FRAME.
- frame_cnt holds its value while in IDLE.
- Simultaneous X and Y bounce (corner hit): both flip; bounce_x=bounce_y=1 in the same cycle.
- A frame_tick arriving during CALC/COMMIT is impossible (vsync spans many lines) and is ignored.
- Reset mid-operation: all registers return to reset values immediately; no partial commit.
- Outputs are held stable between pos_update pulses.
- Legal configuration: BLOCK_SIZE+STEP_X < H_DISP and BLOCK_SIZE+STEP_Y < V_DISP.

Decomposition:
- Shared package hdmi_timing_pkg holds:
  - H_DISP/V_DISP constants for 1280x720 (shared with video_driver);
  - the state encoding IDLE/WAIT_FRAME/CALC/COMMIT;
  - the 11-bit coordinate width constant.
- One natural sub-module, axis_bounce: pure combinational single-axis next-position/direction calculator. Parameterised by limit and step, instantiated twice (X with H_DISP/STEP_X, Y with V_DISP/STEP_Y).
- The FSM, frame divider and vsync edge detect stay in block_move_ctrl.

Test Plan:
1. Reset, hold move_en=0, apply 5 vsync pulses -> block_x=0, block_y=0, dir_x=dir_y=1, pos_update never asserted.
2. move_en=1, defaults, one vsync rising edge at cycle N -> pos_update high only at N+2; block_x=2, block_y=2.
3. X_INIT=1238, dir right, one frame -> block_x=1240, bounce_x=1, dir_x=0. Next frame -> block_x=1238.
4. X_INIT=1240, Y_INIT=680, one frame -> corner hit: block_x=1240, block_y=680, bounce_x=bounce_y=1 in the same cycle, dir_x=dir_y=0.
5. FRAME_DIV=3, 9 vsync edges -> exactly 3 pos_update pulses, on the 3rd, 6th and 9th edges. Drop move_en after the 4th edge, then resume 2 frames later -> frame_cnt continues from its held value.
6. Assert sys_rst_n=0 in the CALC cycle -> outputs at reset values that same cycle with no pos_update. After release, normal stepping resumes from X_INIT/Y_INIT.
